// File: rtl/game_pkg.sv
// Shared types and constants for the memorization game sequencer.
// Digit masking and active-digit helpers live here too.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHOW,
        ENTER,
        CHECK,
        RESULT,
        GAMEOVER
    } gameState_t;

    localparam logic [3:0] KEY_CLEAR  = 4'hF;
    localparam int         DIGIT_W    = 4;
    localparam int         MAX_DIGITS = 4;

    // Number of digits in play at a given level, capped at four.
    function automatic logic [2:0] activeDigits(input logic [3:0] lvl);
        return (lvl > 4'd4) ? 3'd4 : lvl[2:0];
    endfunction

    // Zero every nibble above the active digit count.
    function automatic logic [15:0] maskDigits(
        input logic [15:0] value,
        input logic [2:0]  nd
    );
        logic [15:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < int'(nd)) begin
                mask[i*DIGIT_W +: DIGIT_W] = 4'hF;
            end
        end
        return value & mask;
    endfunction

endpackage

// File: rtl/game_sequencer_phase_timer.sv
// Tick counter shared by the show and result phases.
// Held at zero while cleared; flags the tick that reaches the terminal count.
module phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       tick,
    input  logic [7:0] termCount,
    output logic       expired
);

    logic [7:0] count;

    // Count ticks only while the owning phase is active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 8'd1;
        end
    end

    assign expired = tick && !clear && (count == termCount - 8'd1);

endmodule

// File: rtl/game_sequencer.sv
// Round controller: latch target, show it, collect digits, score, advance.
// One explicit FSM owns the display phase, target, entry and level.
module game_sequencer
    import game_pkg::*;
#(
    parameter int SHOW_TICKS   = 3,
    parameter int RESULT_TICKS = 2,
    parameter int MAX_LEVEL    = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic [15:0] randInt,
    input  logic        keyValid,
    input  logic [3:0]  keyCode,
    output logic        displayPhase,
    output logic [15:0] target,
    output logic [15:0] userInt,
    output logic [2:0]  digitCount,
    output logic        resultValid,
    output logic        correct,
    output logic [3:0]  level,
    output logic        gameOver
);

    gameState_t state;
    gameState_t nextState;

    logic [2:0] nd;
    logic       timerClear;
    logic [7:0] timerTerm;
    logic       timerDone;
    logic       keyDigit;
    logic       lastDigit;

    assign nd         = activeDigits(level);
    assign timerClear = !((state == SHOW) || (state == RESULT));
    assign timerTerm  = (state == SHOW) ? 8'(SHOW_TICKS) : 8'(RESULT_TICKS);
    assign keyDigit   = keyValid && (keyCode != KEY_CLEAR);
    assign lastDigit  = keyDigit && ((digitCount + 3'd1) == nd);

    phase_timer uTimer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timerClear),
        .tick     (tick),
        .termCount(timerTerm),
        .expired  (timerDone)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:     if (start) nextState = LOAD;
            LOAD:     nextState = SHOW;
            SHOW:     if (timerDone) nextState = ENTER;
            ENTER:    if (lastDigit) nextState = CHECK;
            CHECK:    nextState = RESULT;
            RESULT: begin
                if (timerDone) begin
                    nextState = correct ? LOAD : GAMEOVER;
                end
            end
            GAMEOVER: if (start) nextState = LOAD;
            default:  nextState = IDLE;
        endcase
    end

    // Registered phase flags, target, entry shifter, score and level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            displayPhase <= 1'b0;
            resultValid  <= 1'b0;
            gameOver     <= 1'b0;
            target       <= '0;
            userInt      <= '0;
            digitCount   <= '0;
            correct      <= 1'b0;
            level        <= 4'd1;
        end else begin
            displayPhase <= (nextState == SHOW);
            resultValid  <= (nextState == RESULT);
            gameOver     <= (nextState == GAMEOVER);
            unique case (state)
                IDLE, GAMEOVER: begin
                    if (start) level <= 4'd1;
                end
                LOAD: begin
                    target     <= maskDigits(randInt, nd);
                    userInt    <= '0;
                    digitCount <= '0;
                end
                ENTER: begin
                    if (keyValid) begin
                        if (keyCode == KEY_CLEAR) begin
                            userInt    <= '0;
                            digitCount <= '0;
                        end else begin
                            userInt    <= {userInt[11:0], keyCode};
                            digitCount <= digitCount + 3'd1;
                        end
                    end
                end
                CHECK: begin
                    correct <= (userInt == target);
                end
                RESULT: begin
                    if (timerDone && correct && (level != 4'(MAX_LEVEL))) begin
                        level <= level + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic [15:0] randInt = '0;
    logic        keyValid = 1'b0;
    logic [3:0]  keyCode = '0;
    logic        displayPhase;
    logic [15:0] target;
    logic [15:0] userInt;
    logic [2:0]  digitCount;
    logic        resultValid;
    logic        correct;
    logic [3:0]  level;
    logic        gameOver;

    int checks = 0;
    int errors = 0;

    game_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start       (start),
        .randInt     (randInt),
        .keyValid    (keyValid),
        .keyCode     (keyCode),
        .displayPhase(displayPhase),
        .target      (target),
        .userInt     (userInt),
        .digitCount  (digitCount),
        .resultValid (resultValid),
        .correct     (correct),
        .level       (level),
        .gameOver    (gameOver)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseTick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pressKey(input logic [3:0] k);
        keyValid = 1'b1;
        keyCode  = k;
        cyc();
        keyValid = 1'b0;
    endtask

    // Plays a full correct round; call while the DUT sits in LOAD.
    task automatic runRound(input logic [15:0] rnd, input int nd);
        randInt = rnd;
        cyc();
        repeat (3) pulseTick();
        for (int k = nd - 1; k >= 0; k--) begin
            pressKey(rnd[k*4 +: 4]);
        end
        cyc();
        repeat (2) pulseTick();
    endtask

    task automatic test_reset();
        repeat (2) cyc();
        checks++;
        if ({displayPhase, resultValid, correct, gameOver} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000",
                     {displayPhase, resultValid, correct, gameOver});
        end
        checks++;
        if (level !== 4'd1) begin
            errors++;
            $display("FAIL reset_level got %0d want 1", level);
        end
        checks++;
        if ({target, userInt, digitCount} !== 35'd0) begin
            errors++;
            $display("FAIL reset_data got %h %h %0d want 0",
                     target, userInt, digitCount);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_first_round();
        randInt = 16'h1234;
        pulseStart();
        checks++;
        if (displayPhase !== 1'b0) begin
            errors++;
            $display("FAIL load_display got %b want 0", displayPhase);
        end
        cyc();
        checks++;
        if (displayPhase !== 1'b1 || target !== 16'h0004) begin
            errors++;
            $display("FAIL show_target got %b %h want 1 0004",
                     displayPhase, target);
        end
        pulseTick();
        pulseTick();
        checks++;
        if (displayPhase !== 1'b1) begin
            errors++;
            $display("FAIL show_two_ticks got %b want 1", displayPhase);
        end
        pulseTick();
        checks++;
        if (displayPhase !== 1'b0) begin
            errors++;
            $display("FAIL show_third_tick got %b want 0", displayPhase);
        end
        pressKey(4'h4);
        checks++;
        if (userInt !== 16'h0004 || digitCount !== 3'd1 || resultValid !== 1'b0) begin
            errors++;
            $display("FAIL l1_entry got %h %0d %b want 0004 1 0",
                     userInt, digitCount, resultValid);
        end
        cyc();
        checks++;
        if (resultValid !== 1'b1 || correct !== 1'b1) begin
            errors++;
            $display("FAIL l1_result got %b %b want 1 1", resultValid, correct);
        end
        pulseTick();
        checks++;
        if (resultValid !== 1'b1) begin
            errors++;
            $display("FAIL l1_result_hold got %b want 1", resultValid);
        end
        pulseTick();
        checks++;
        if (level !== 4'd2 || resultValid !== 1'b0) begin
            errors++;
            $display("FAIL l1_advance got %0d %b want 2 0", level, resultValid);
        end
    endtask

    task automatic test_ignored_and_clear();
        randInt = 16'h5612;
        pulseTick();
        checks++;
        if (displayPhase !== 1'b1 || target !== 16'h0012) begin
            errors++;
            $display("FAIL l2_show got %b %h want 1 0012", displayPhase, target);
        end
        pressKey(4'h9);
        pulseStart();
        checks++;
        if (userInt !== 16'h0 || digitCount !== 3'd0 || displayPhase !== 1'b1) begin
            errors++;
            $display("FAIL show_ignore got %h %0d %b want 0000 0 1",
                     userInt, digitCount, displayPhase);
        end
        pulseTick();
        pulseTick();
        checks++;
        if (displayPhase !== 1'b1) begin
            errors++;
            $display("FAIL entry_tick_uncounted got %b want 1", displayPhase);
        end
        pulseTick();
        pulseStart();
        checks++;
        if (displayPhase !== 1'b0 || level !== 4'd2 || digitCount !== 3'd0
            || resultValid !== 1'b0) begin
            errors++;
            $display("FAIL enter_start_ignore got %b %0d %0d %b want 0 2 0 0",
                     displayPhase, level, digitCount, resultValid);
        end
        pressKey(4'h7);
        checks++;
        if (userInt !== 16'h0007 || digitCount !== 3'd1) begin
            errors++;
            $display("FAIL key7 got %h %0d want 0007 1", userInt, digitCount);
        end
        pressKey(4'hF);
        checks++;
        if (userInt !== 16'h0000 || digitCount !== 3'd0) begin
            errors++;
            $display("FAIL keyF got %h %0d want 0000 0", userInt, digitCount);
        end
        pressKey(4'h1);
        cyc();
        checks++;
        if (userInt !== 16'h0001 || digitCount !== 3'd1 || resultValid !== 1'b0) begin
            errors++;
            $display("FAIL key1_nocheck got %h %0d %b want 0001 1 0",
                     userInt, digitCount, resultValid);
        end
        pressKey(4'h2);
        cyc();
        checks++;
        if (resultValid !== 1'b1 || correct !== 1'b1 || userInt !== 16'h0012) begin
            errors++;
            $display("FAIL l2_result got %b %b %h want 1 1 0012",
                     resultValid, correct, userInt);
        end
        repeat (2) pulseTick();
        checks++;
        if (level !== 4'd3) begin
            errors++;
            $display("FAIL l2_advance got %0d want 3", level);
        end
    endtask

    task automatic test_wrong_entry();
        runRound(16'h0789, 3);
        checks++;
        if (level !== 4'd4) begin
            errors++;
            $display("FAIL l3_advance got %0d want 4", level);
        end
        randInt = 16'hA5C3;
        cyc();
        checks++;
        if (target !== 16'hA5C3) begin
            errors++;
            $display("FAIL l4_target got %h want a5c3", target);
        end
        repeat (3) pulseTick();
        pressKey(4'hA);
        pressKey(4'h5);
        pressKey(4'hC);
        pressKey(4'h2);
        checks++;
        if (userInt !== 16'hA5C2 || digitCount !== 3'd4) begin
            errors++;
            $display("FAIL l4_entry got %h %0d want a5c2 4", userInt, digitCount);
        end
        cyc();
        checks++;
        if (resultValid !== 1'b1 || correct !== 1'b0) begin
            errors++;
            $display("FAIL l4_result got %b %b want 1 0", resultValid, correct);
        end
        pulseTick();
        checks++;
        if (resultValid !== 1'b1 || gameOver !== 1'b0) begin
            errors++;
            $display("FAIL l4_result_hold got %b %b want 1 0", resultValid, gameOver);
        end
        pulseTick();
        checks++;
        if (gameOver !== 1'b1 || resultValid !== 1'b0 || level !== 4'd4) begin
            errors++;
            $display("FAIL gameover got %b %b %0d want 1 0 4",
                     gameOver, resultValid, level);
        end
        pressKey(4'h3);
        checks++;
        if (gameOver !== 1'b1 || userInt !== 16'hA5C2) begin
            errors++;
            $display("FAIL gameover_key got %b %h want 1 a5c2", gameOver, userInt);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] rnd;
        int          nd;
        int          expLevel;
        pulseStart();
        checks++;
        if (level !== 4'd1 || gameOver !== 1'b0) begin
            errors++;
            $display("FAIL restart got %0d %b want 1 0", level, gameOver);
        end
        for (int i = 0; i < 9; i++) begin
            rnd      = 16'h1234 + 16'(i) * 16'h0111;
            nd       = (i + 1 > 4) ? 4 : i + 1;
            expLevel = (i + 2 > 9) ? 9 : i + 2;
            runRound(rnd, nd);
            checks++;
            if (level !== 4'(expLevel) || gameOver !== 1'b0) begin
                errors++;
                $display("FAIL sat_round%0d got %0d %b want %0d 0",
                         i + 1, level, gameOver, expLevel);
            end
        end
    endtask

    task automatic test_reset_mid_enter();
        randInt = 16'hBEEF;
        cyc();
        checks++;
        if (target !== 16'hBEEF) begin
            errors++;
            $display("FAIL l9_target got %h want beef", target);
        end
        repeat (3) pulseTick();
        pressKey(4'hB);
        pressKey(4'hE);
        checks++;
        if (userInt !== 16'h00BE || digitCount !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset got %h %0d want 00be 2", userInt, digitCount);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({displayPhase, resultValid, correct, gameOver} !== 4'b0000
            || level !== 4'd1 || {target, userInt, digitCount} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset got %b %0d %h %h %0d want 0000 1 0 0 0",
                     {displayPhase, resultValid, correct, gameOver},
                     level, target, userInt, digitCount);
        end
        #2;
        rst = 1'b0;
        cyc();
        pressKey(4'h5);
        pulseTick();
        checks++;
        if (userInt !== 16'h0 || digitCount !== 3'd0 || displayPhase !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got %h %0d %b want 0000 0 0",
                     userInt, digitCount, displayPhase);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_first_round();
        test_ignored_and_clear();
        test_wrong_entry();
        test_saturation();
        test_reset_mid_enter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
